// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader
//
// Watches a multiplexed, active-low, common-anode 7-segment display bus.
// The block waits for each digit slot to hold steady, then decodes the
// segment pattern back to a 4-bit BCD code. It collects one code per digit
// into a frame and offers that frame on a valid/ready output.
//
// Parameters:
//   NDIG        number of multiplexed digits (1..8)
//   STABLE_CYC  identical samples required before a digit is captured (>=2)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   an_n       digit enables, active-low, bit i selects digit i
//   seg_n      segments, active-low, {a,b,c,d,e,f,g} on bits 6..0
//   out_bcd    held frame, digit i at [4i+3:4i]
//   out_err    per-digit invalid-pattern flags for the held frame
//   out_valid  frame available
//   out_ready  consumer accepts the frame when valid&&ready at a clock edge
//   overrun    one-cycle pulse when a completed frame is dropped
module seg7_scan_reader #(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NDIG-1:0]      an_n,
  input  logic [6:0]           seg_n,
  output logic [4*NDIG-1:0]    out_bcd,
  output logic [NDIG-1:0]      out_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overrun
);

  localparam int CW = $clog2(STABLE_CYC);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYC - 1);

  typedef enum logic {SETTLE, HOLD} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [NDIG-1:0]        smp_an;
  logic [6:0]             smp_seg;
  logic [NDIG-1:0][3:0]   dbuf;
  logic [NDIG-1:0]        ebuf;
  logic [NDIG-1:0]        seen;

  logic                   change;
  logic                   capture;
  logic                   complete;
  logic                   one_low;
  logic [IW-1:0]          cap_idx;
  logic [3:0]             dig_code;
  logic                   dig_err;
  logic [NDIG-1:0][3:0]   dbuf_next;
  logic [NDIG-1:0]        ebuf_next;
  logic [NDIG-1:0]        seen_next;
  int                     lows;

  // Segment pattern back to BCD; blank is a legal "off" digit and is not
  // flagged, anything unrecognised becomes E with its error bit set.
  always_comb begin
    dig_err  = 1'b0;
    dig_code = 4'hE;
    case (smp_seg)
      7'b0000001: dig_code = 4'd0;
      7'b1001111: dig_code = 4'd1;
      7'b0010010: dig_code = 4'd2;
      7'b0000110: dig_code = 4'd3;
      7'b1001100: dig_code = 4'd4;
      7'b0100100: dig_code = 4'd5;
      7'b0100000: dig_code = 4'd6;
      7'b0001111: dig_code = 4'd7;
      7'b0000000: dig_code = 4'd8;
      7'b0000100: dig_code = 4'd9;
      7'b1111111: dig_code = 4'hF;
      default: begin
        dig_code = 4'hE;
        dig_err  = 1'b1;
      end
    endcase
  end

  // Capture qualification and next-state of the digit buffer. A capture
  // needs exactly one enabled anode; no anode or several anodes at once are
  // ignored silently, since they occur normally during scan transitions.
  always_comb begin
    lows    = 0;
    cap_idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (!smp_an[i]) begin
        lows    = lows + 1;
        cap_idx = IW'(i);
      end
    end
    one_low = (lows == 1);

    change  = ({an_n, seg_n} != {smp_an, smp_seg});
    capture = (state == SETTLE) && !change && (cnt == CNT_LAST) && one_low;

    dbuf_next = dbuf;
    ebuf_next = ebuf;
    seen_next = seen;
    if (capture) begin
      dbuf_next[cap_idx] = dig_code;
      ebuf_next[cap_idx] = dig_err;
      seen_next[cap_idx] = 1'b1;
    end
    complete = capture && (&seen_next);
  end

  // Sampling, settle/hold FSM, digit buffer and output handshake. The FSM
  // parks in HOLD after the settle period so a long stable slot yields a
  // single capture. A completed frame is loaded if the output slot is free
  // or being emptied on this same edge; otherwise it is dropped and overrun
  // pulses while the held frame stays untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= SETTLE;
      cnt       <= '0;
      smp_an    <= '0;
      smp_seg   <= '0;
      dbuf      <= '0;
      ebuf      <= '0;
      seen      <= '0;
      out_bcd   <= '0;
      out_err   <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      smp_an  <= an_n;
      smp_seg <= seg_n;
      overrun <= 1'b0;

      case (state)
        SETTLE: begin
          if (change) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= HOLD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HOLD: begin
          if (change) begin
            cnt   <= '0;
            state <= SETTLE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= SETTLE;
        end
      endcase

      dbuf <= dbuf_next;
      ebuf <= ebuf_next;

      if (complete) begin
        seen <= '0;
        if (!out_valid || out_ready) begin
          out_bcd   <= dbuf_next;
          out_err   <= ebuf_next;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else begin
        seen <= seen_next;
        if (out_valid && out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader
//
// Self-checking bench for seg7_scan_reader with NDIG=4, STABLE_CYC=4.
// Whole frames come from a table of segment patterns plus their expected
// frame. Hand-written sequences cover glitches, invalid anode patterns,
// backpressure with overrun, back-to-back loading, and reset mid-frame.
module tb_seg7_scan_reader;

  localparam int NDIG       = 4;
  localparam int STABLE_CYC = 4;
  localparam int HOLDC      = 10;

  logic                clk;
  logic                rst_n;
  logic [NDIG-1:0]     an_n;
  logic [6:0]          seg_n;
  logic [4*NDIG-1:0]   out_bcd;
  logic [NDIG-1:0]     out_err;
  logic                out_valid;
  logic                out_ready;
  logic                overrun;

  seg7_scan_reader #(.NDIG(NDIG), .STABLE_CYC(STABLE_CYC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .an_n      (an_n),
    .seg_n     (seg_n),
    .out_bcd   (out_bcd),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Accepted frames and overrun pulses, sampled on the falling edge.
  int          acc_cnt = 0;
  int          ovr_cnt = 0;
  logic [15:0] acc_bcd = '0;
  logic [3:0]  acc_err = '0;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      acc_cnt = acc_cnt + 1;
      acc_bcd = out_bcd;
      acc_err = out_err;
    end
    if (overrun) ovr_cnt = ovr_cnt + 1;
  end

  typedef struct {
    logic [3:0][6:0] segs;
    logic [15:0]     bcd;
    logic [3:0]      err;
  } vec_t;

  vec_t vecs [4];

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] BAD   = 7'b1010101;

  function automatic logic [6:0] segOf(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return BLANK;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Show one digit slot on the bus for a number of cycles.
  task automatic applyStimulus(input int idx, input logic [6:0] pat, input int cycles);
    an_n  = ~(4'b0001 << idx);
    seg_n = pat;
    repeat (cycles) tick();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  int a0;
  int o0;

  initial begin
    vecs[0].segs = {segOf(1), segOf(2), segOf(3), segOf(4)};
    vecs[0].bcd  = 16'h1234;
    vecs[0].err  = 4'b0000;
    vecs[1].segs = {segOf(0), BLANK, BAD, segOf(0)};
    vecs[1].bcd  = 16'h0FE0;
    vecs[1].err  = 4'b0010;
    vecs[2].segs = {segOf(8), segOf(7), segOf(6), segOf(5)};
    vecs[2].bcd  = 16'h8765;
    vecs[2].err  = 4'b0000;
    vecs[3].segs = {segOf(0), segOf(9), segOf(0), segOf(9)};
    vecs[3].bcd  = 16'h0909;
    vecs[3].err  = 4'b0000;

    rst_n     = 1'b0;
    an_n      = 4'hF;
    seg_n     = BLANK;
    out_ready = 1'b1;
    repeat (3) tick();
    checkOutput("reset out_bcd", 32'(out_bcd), 32'h0);
    checkOutput("reset out_err", 32'(out_err), 32'h0);
    checkOutput("reset out_valid", 32'(out_valid), 32'h0);
    checkOutput("reset overrun", 32'(overrun), 32'h0);
    rst_n = 1'b1;

    // Table-driven frames, consumer always ready.
    for (int v = 0; v < 4; v++) begin
      a0 = acc_cnt;
      o0 = ovr_cnt;
      for (int d = 0; d < NDIG; d++) applyStimulus(d, vecs[v].segs[d], HOLDC);
      checkOutput($sformatf("vec%0d frames", v), 32'(acc_cnt - a0), 32'd1);
      checkOutput($sformatf("vec%0d bcd", v), 32'(acc_bcd), 32'(vecs[v].bcd));
      checkOutput($sformatf("vec%0d err", v), 32'(acc_err), 32'(vecs[v].err));
      checkOutput($sformatf("vec%0d overrun", v), 32'(ovr_cnt - o0), 32'd0);
    end

    // Short blank glitches on digit 0 must never be captured.
    a0 = acc_cnt;
    applyStimulus(0, segOf(8), 3);
    applyStimulus(0, BLANK, 2);
    applyStimulus(0, segOf(8), HOLDC);
    applyStimulus(0, BLANK, STABLE_CYC - 1);
    applyStimulus(1, segOf(1), HOLDC);
    applyStimulus(2, segOf(2), HOLDC);
    applyStimulus(3, segOf(3), HOLDC);
    checkOutput("glitch frames", 32'(acc_cnt - a0), 32'd1);
    checkOutput("glitch bcd", 32'(acc_bcd), 32'h3218);
    checkOutput("glitch err", 32'(acc_err), 32'h0);

    // No anode or all anodes enabled: nothing is captured.
    a0 = acc_cnt;
    an_n = 4'b0000; seg_n = segOf(5); repeat (20) tick();
    an_n = 4'b1111; seg_n = segOf(6); repeat (20) tick();
    applyStimulus(0, segOf(4), HOLDC);
    applyStimulus(1, segOf(4), HOLDC);
    applyStimulus(2, segOf(4), HOLDC);
    checkOutput("noanode frames", 32'(acc_cnt - a0), 32'd0);
    checkOutput("noanode valid", 32'(out_valid), 32'd0);
    applyStimulus(3, segOf(4), HOLDC);
    checkOutput("noanode last bcd", 32'(acc_bcd), 32'h4444);

    // Backpressure: first frame held, second dropped with overrun.
    out_ready = 1'b0;
    a0 = acc_cnt;
    o0 = ovr_cnt;
    for (int d = 0; d < NDIG; d++) applyStimulus(d, segOf(1), HOLDC);
    checkOutput("bp first valid", 32'(out_valid), 32'd1);
    checkOutput("bp first bcd", 32'(out_bcd), 32'h1111);
    for (int d = 0; d < NDIG; d++) applyStimulus(d, segOf(2), HOLDC);
    checkOutput("bp held bcd", 32'(out_bcd), 32'h1111);
    checkOutput("bp held valid", 32'(out_valid), 32'd1);
    checkOutput("bp overrun pulses", 32'(ovr_cnt - o0), 32'd1);

    // Ready rises exactly on the third completion: back-to-back load.
    for (int d = 0; d < NDIG - 1; d++) applyStimulus(d, segOf(3), HOLDC);
    applyStimulus(3, BAD, STABLE_CYC);
    out_ready = 1'b1;
    tick();
    checkOutput("b2b valid", 32'(out_valid), 32'd1);
    checkOutput("b2b bcd", 32'(out_bcd), 32'hE333);
    checkOutput("b2b err", 32'(out_err), 32'b1000);
    checkOutput("b2b accepted old", 32'(acc_bcd), 32'h1111);
    checkOutput("b2b overrun", 32'(ovr_cnt - o0), 32'd1);
    tick();
    checkOutput("b2b drained", 32'(out_valid), 32'd0);
    checkOutput("b2b accepted new", 32'(acc_bcd), 32'hE333);
    checkOutput("b2b accept count", 32'(acc_cnt - a0), 32'd2);

    // Reset after capturing digits 0 and 1.
    applyStimulus(0, segOf(7), HOLDC);
    applyStimulus(1, segOf(7), HOLDC);
    rst_n = 1'b0;
    tick();
    checkOutput("midreset out_bcd", 32'(out_bcd), 32'h0);
    checkOutput("midreset out_err", 32'(out_err), 32'h0);
    checkOutput("midreset out_valid", 32'(out_valid), 32'h0);
    checkOutput("midreset overrun", 32'(overrun), 32'h0);
    rst_n = 1'b1;
    a0 = acc_cnt;
    applyStimulus(2, segOf(5), HOLDC);
    applyStimulus(3, segOf(6), HOLDC);
    checkOutput("postreset partial frames", 32'(acc_cnt - a0), 32'd0);
    checkOutput("postreset partial valid", 32'(out_valid), 32'd0);
    applyStimulus(0, segOf(1), HOLDC);
    applyStimulus(1, segOf(2), HOLDC);
    checkOutput("postreset frames", 32'(acc_cnt - a0), 32'd1);
    checkOutput("postreset bcd", 32'(acc_bcd), 32'h6521);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
